// File: rtl/seq_match_logger.sv
// Timestamps rising edges of a sequence detector's match output and buffers
// them in a first-word-fall-through FIFO, with a saturating match counter.
`timescale 1ns/1ps
module seq_match_logger #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     y_in,
    input  logic                     clear,
    input  logic                     rd_en,
    output logic [TS_W-1:0]          rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         match_count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic             y_q;
    logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TS_W-1:0]  mem_q [DEPTH];
    logic             edge_s, push_s, pop_s, drop_s;

    // Next-state logic for edge qualification, pointers, flags and counters
    always_comb begin
        ts_d     = ts_q + TS_W'(1);
        edge_s   = y_in & ~y_q;
        pop_s    = rd_en & ~empty_q & ~clear;
        // a simultaneous pop frees a slot, so a full FIFO still accepts the push
        push_s   = edge_s & ~clear & (~full_q | pop_s);
        drop_s   = edge_s & ~clear & full_q & ~pop_s;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + LW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + LW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (edge_s && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
            if (drop_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end
        // wrap bit makes the pointer difference span 0..DEPTH unambiguously
        level_d = wr_ptr_d - rd_ptr_d;
        empty_d = (level_d == LW'(0));
        full_d  = (level_d == LW'(DEPTH));
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q     <= '0;
            y_q      <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ts_q     <= ts_d;
            y_q      <= y_in;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    // Timestamp storage; contents are meaningless outside the valid window
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem_q[wr_ptr_q[AW-1:0]] <= ts_q;
        end
    end

    assign rd_data     = mem_q[rd_ptr_q[AW-1:0]];
    assign empty       = empty_q;
    assign full        = full_q;
    assign level       = level_q;
    assign match_count = cnt_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_seq_match_logger.sv
// Scoreboard bench: one wide instance and one narrow (TS_W=4, CNT_W=2) instance
// share the same stimulus, checked against a queue-based reference.
`timescale 1ns/1ps
module tb_seq_match_logger;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        y_in = 1'b0;
    logic        clear = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] a_rd;
    logic        a_empty, a_full, a_ovf;
    logic [3:0]  a_level;
    logic [7:0]  a_cnt;
    logic [3:0]  b_rd;
    logic        b_empty, b_full, b_ovf;
    logic [3:0]  b_level;
    logic [1:0]  b_cnt;

    int          checks = 0;
    int          errors = 0;
    int          m_ts = 0;
    logic        m_yq = 1'b0;
    int          m_cnt = 0;
    logic        m_ovf = 1'b0;
    int          sb[$];

    seq_match_logger #(.DEPTH(DEPTH), .TS_W(16), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .y_in(y_in), .clear(clear), .rd_en(rd_en),
        .rd_data(a_rd), .empty(a_empty), .full(a_full), .level(a_level),
        .match_count(a_cnt), .overflow(a_ovf)
    );

    seq_match_logger #(.DEPTH(DEPTH), .TS_W(4), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset), .y_in(y_in), .clear(clear), .rd_en(rd_en),
        .rd_data(b_rd), .empty(b_empty), .full(b_full), .level(b_level),
        .match_count(b_cnt), .overflow(b_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle of stimulus; the reference queue is updated alongside
    task automatic drive(input logic y, input logic rd, input logic clr);
        @(negedge clk);
        reset = 1'b0; y_in = y; rd_en = rd; clear = clr;
        if (clr) begin
            sb.delete(); m_cnt = 0; m_ovf = 1'b0;
        end else begin
            if (rd && sb.size() > 0) void'(sb.pop_front());
            if (y && !m_yq) begin
                if (m_cnt < 255) m_cnt++;
                if (sb.size() < DEPTH) sb.push_back(m_ts);
                else m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        m_yq = y; m_ts++;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; y_in = 1'b1; rd_en = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete(); m_ts = 0; m_yq = 1'b0; m_cnt = 0; m_ovf = 1'b0;
    endtask

    // Pop every queued stamp, comparing the head on both instances first
    task automatic drain(input string tag);
        int n;
        int h;
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            h = sb[0];
            checks++;
            if (a_rd !== 16'(h)) begin errors++; $display("FAIL %s_a_rd[%0d]: got %0d want %0d", tag, i, a_rd, h); end
            checks++;
            if (b_rd !== 4'(h)) begin errors++; $display("FAIL %s_b_rd[%0d]: got %0d want %0d", tag, i, b_rd, 4'(h)); end
            drive(1'b0, 1'b1, 1'b0);
        end
        checks++;
        if (a_empty !== 1'b1 || a_level !== 4'd0) begin errors++; $display("FAIL %s_drained: empty %0b level %0d want 1/0", tag, a_empty, a_level); end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", a_empty); end
        checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", a_full); end
        checks++; if (a_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", a_level); end
        checks++; if (a_cnt !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", a_cnt); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", a_ovf); end
    endtask

    task automatic test_single_pulses();
        int exp_s[3] = '{3, 7, 12};
        while (m_ts <= 13) drive((m_ts == 3) || (m_ts == 7) || (m_ts == 12), 1'b0, 1'b0);
        checks++; if (a_level !== 4'd3) begin errors++; $display("FAIL pulses_level: got %0d want 3", a_level); end
        checks++; if (a_cnt !== 8'd3) begin errors++; $display("FAIL pulses_count: got %0d want 3", a_cnt); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a_rd !== 16'(exp_s[i])) begin errors++; $display("FAIL pulses_rd[%0d]: got %0d want %0d", i, a_rd, exp_s[i]); end
            drive(1'b0, 1'b1, 1'b0);
        end
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL pulses_empty: got %0b want 1", a_empty); end
        drive(1'b0, 1'b1, 1'b0);
        checks++; if (a_level !== 4'd0 || a_empty !== 1'b1) begin errors++; $display("FAIL pulses_rd_empty: level %0d empty %0b want 0/1", a_level, a_empty); end
    endtask

    task automatic test_held_high();
        while (m_ts < 20) drive(1'b0, 1'b0, 1'b0);
        repeat (4) drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (a_level !== 4'd1) begin errors++; $display("FAIL held_level: got %0d want 1", a_level); end
        checks++; if (a_cnt !== 8'd4) begin errors++; $display("FAIL held_count: got %0d want 4", a_cnt); end
        checks++; if (a_rd !== 16'd20) begin errors++; $display("FAIL held_rd: got %0d want 20", a_rd); end
        drain("held");
    endtask

    task automatic test_detector_stream();
        logic [12:0] din = 13'b0111010101010;
        logic [3:0]  hist = 4'b0000;
        logic        y_cur = 1'b0;
        for (int i = 12; i >= 0; i--) begin
            drive(y_cur, 1'b0, 1'b0);
            hist = {hist[2:0], din[i]};
            y_cur = (hist == 4'b1010);
        end
        drive(y_cur, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (a_level !== 4'd4) begin errors++; $display("FAIL stream_level: got %0d want 4", a_level); end
        checks++; if (a_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL stream_count: got %0d want %0d", a_cnt, m_cnt); end
        drain("stream");
    endtask

    task automatic test_overflow();
        drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0);
        end
        checks++; if (a_full !== 1'b1 || a_level !== 4'd8) begin errors++; $display("FAIL ovf_full: full %0b level %0d want 1/8", a_full, a_level); end
        checks++; if (a_ovf !== 1'b1 || b_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b/%0b want 1", a_ovf, b_ovf); end
        checks++; if (a_cnt !== 8'd9) begin errors++; $display("FAIL ovf_count: got %0d want 9", a_cnt); end
        checks++; if (b_cnt !== 2'd3) begin errors++; $display("FAIL sat_count: got %0d want 3", b_cnt); end
        drain("ovf");
        checks++; if (a_ovf !== m_ovf) begin errors++; $display("FAIL ovf_sticky: got %0b want %0b", a_ovf, m_ovf); end
    endtask

    task automatic test_back_to_back();
        int t_new;
        int n;
        drive(1'b0, 1'b0, 1'b1);
        checks++; if (a_ovf !== 1'b0 || a_cnt !== 8'd0) begin errors++; $display("FAIL b2b_clear: ovf %0b cnt %0d want 0/0", a_ovf, a_cnt); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0);
        end
        checks++; if (a_full !== 1'b1) begin errors++; $display("FAIL b2b_fill: got %0b want 1", a_full); end
        checks++; if (a_rd !== 16'(sb[0])) begin errors++; $display("FAIL b2b_head: got %0d want %0d", a_rd, sb[0]); end
        t_new = m_ts;
        drive(1'b1, 1'b1, 1'b0);
        checks++; if (a_level !== 4'd8 || a_full !== 1'b1) begin errors++; $display("FAIL b2b_level: level %0d full %0b want 8/1", a_level, a_full); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %0b want 0", a_ovf); end
        n = sb.size();
        checks++; if (n != 8 || sb[n-1] != t_new) begin errors++; $display("FAIL b2b_tail_model: size %0d want 8", n); end
        drain("b2b");
    endtask

    task automatic test_wrap_clear();
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        apply_reset();
        checks++; if (a_empty !== 1'b1 || a_level !== 4'd0) begin errors++; $display("FAIL midreset: empty %0b level %0d want 1/0", a_empty, a_level); end
        while (m_ts < 17) drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (b_rd !== 4'd1) begin errors++; $display("FAIL wrap_rd: got %0d want 1", b_rd); end
        checks++; if (a_rd !== 16'd17) begin errors++; $display("FAIL wide_rd: got %0d want 17", a_rd); end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        checks++; if (a_level !== 4'd0 || b_level !== 4'd0) begin errors++; $display("FAIL clear_level: got %0d/%0d want 0", a_level, b_level); end
        checks++; if (a_cnt !== 8'd0 || b_cnt !== 2'd0) begin errors++; $display("FAIL clear_count: got %0d/%0d want 0", a_cnt, b_cnt); end
        checks++; if (a_ovf !== 1'b0 || a_empty !== 1'b1) begin errors++; $display("FAIL clear_flags: ovf %0b empty %0b want 0/1", a_ovf, a_empty); end
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (a_level !== 4'd1 || a_cnt !== 8'd1) begin errors++; $display("FAIL reedge: level %0d cnt %0d want 1/1", a_level, a_cnt); end
        drain("reedge");
    endtask

    initial begin
        test_reset();
        test_single_pulses();
        test_held_high();
        test_detector_stream();
        test_overflow();
        test_back_to_back();
        test_wrap_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
